// File: rtl/lsu_mem_adapter.sv
// -----------------------------------------------------------------------------
// lsu_mem_adapter
//
// Load/store unit that sits between the CPU execute stage and the AXI-Lite
// BRAM bridge. It handles one request at a time. For stores it builds the byte
// strobes and the lane-replicated write data. For loads it word-aligns the
// address, then extracts and sign/zero-extends the returned lane. This covers
// RV32I LB/LH/LW/LBU/LHU and SB/SH/SW.
//
// Parameters
//   TIMEOUT_CYCLES   : WAIT cycles allowed before the access is aborted with
//                      resp_err (1..65535)
//
// Ports
//   clk, reset       : system clock, asynchronous active-high reset
//   req_valid/ready  : request handshake with the execute stage (ready = IDLE)
//   req_we           : 1 = store, 0 = load
//   req_funct3       : RV32I funct3 (access size and signedness)
//   req_addr         : byte address
//   req_wdata        : store data (rs2)
//   resp_valid       : one-cycle completion pulse
//   resp_err         : illegal funct3, timeout, or misalignment (macro only)
//   resp_rdata       : extended load data, 0 for stores and errors
//   mem_strb         : byte strobes to the bridge (0 on loads)
//   mem_write_data   : lane-positioned store data
//   mem_write_addr   : word-aligned store address
//   mem_read_addr    : word-aligned load address
//   mem_write_enable : level, held for the whole of WAIT on stores
//   mem_read_enable  : level, held for the whole of WAIT on loads
//   mem_read_data    : word returned by the bridge
//   mem_done         : bridge completion pulse, read data valid in that cycle
//
// Configuration macro
//   MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are refused
//                      with resp_err and no bus access. When undefined, the
//                      low address bits are ignored for the access size.
// -----------------------------------------------------------------------------
module lsu_mem_adapter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [3:0]  mem_strb,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_write_addr,
   output logic [31:0] mem_read_addr,
   output logic        mem_write_enable,
   output logic        mem_read_enable,
   input  logic [31:0] mem_read_data,
   input  logic        mem_done
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StWait = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   // The counter runs 0..TIMEOUT_CYCLES-1 while in WAIT. Hitting the last
   // value without mem_done means TIMEOUT_CYCLES WAIT cycles have elapsed.
   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q,  state_d;
   logic        we_q,     we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q,    off_d;
   logic [31:0] addr_q,   addr_d;
   logic [31:0] wdata_q,  wdata_d;
   logic [3:0]  strb_q,   strb_d;
   logic        err_q,    err_d;
   logic [31:0] rdata_q,  rdata_d;
   logic [15:0] cnt_q,    cnt_d;

   logic        legalF3;
   logic        reqErr;
   logic [31:0] laneData;
   logic [3:0]  laneStrb;
   logic [4:0]  loadShift;
   logic [31:0] shiftedData;
   logic [31:0] loadData;
`ifdef MISALIGN_TRAP_EN
   logic        misaligned;
`endif

   // Decode the incoming request: check that funct3 is legal for the
   // direction, and build the store lanes. funct3[1:0] selects the size, so
   // byte uses the full offset, half uses only the halfword offset, and word
   // ignores the low address bits.
   always_comb begin
      legalF3 = 1'b0;
      if (req_we) begin
         legalF3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010);
      end else begin
         legalF3 = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                   (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                   (req_funct3 == 3'b101);
      end
`ifdef MISALIGN_TRAP_EN
      misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      reqErr     = !legalF3 || misaligned;
`else
      reqErr     = !legalF3;
`endif
      laneData = 32'h0;
      laneStrb = 4'b0000;
      if (req_we) begin
         case (req_funct3[1:0])
            2'b00: begin
               laneData = {4{req_wdata[7:0]}};
               laneStrb = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
               laneData = {2{req_wdata[15:0]}};
               laneStrb = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
               laneData = req_wdata;
               laneStrb = 4'b1111;
            end
         endcase
      end
   end

   // Load lane extraction from the bridge word, using the latched size and
   // offset. Half accesses shift by the halfword offset only, word accesses
   // never shift. The access is therefore well defined even when the
   // misalignment trap is disabled.
   always_comb begin
      case (funct3_q[1:0])
         2'b00:   loadShift = {off_q, 3'b000};
         2'b01:   loadShift = {off_q[1], 4'b0000};
         default: loadShift = 5'd0;
      endcase
      shiftedData = mem_read_data >> loadShift;
      case (funct3_q)
         3'b000:  loadData = {{24{shiftedData[7]}}, shiftedData[7:0]};
         3'b100:  loadData = {24'h0, shiftedData[7:0]};
         3'b001:  loadData = {{16{shiftedData[15]}}, shiftedData[15:0]};
         3'b101:  loadData = {16'h0, shiftedData[15:0]};
         default: loadData = shiftedData;
      endcase
   end

   // Next-state logic. IDLE latches an accepted request. An illegal request
   // skips straight to RESP, so no enable is ever raised for it. In WAIT,
   // mem_done has priority over the timeout. RESP always lasts one cycle, so
   // with IDLE the enables are guaranteed low for two cycles between
   // accesses.
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      strb_d   = strb_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               off_d    = req_addr[1:0];
               addr_d   = {req_addr[31:2], 2'b00};
               wdata_d  = laneData;
               strb_d   = laneStrb;
               rdata_d  = 32'h0;
               cnt_d    = 16'h0;
               err_d    = reqErr;
               state_d  = reqErr ? StResp : StWait;
            end
         end
         StWait: begin
            if (mem_done) begin
               rdata_d = we_q ? 32'h0 : loadData;
               err_d   = 1'b0;
               state_d = StResp;
            end else if (cnt_q == TimeoutLast) begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers. An asynchronous reset abandons any in-flight access.
   // The enables are decoded from state, so they drop as soon as reset is
   // asserted, and no response is issued for the abandoned request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         strb_q   <= 4'b0000;
         err_q    <= 1'b0;
         rdata_q  <= 32'h0;
         cnt_q    <= 16'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         strb_q   <= strb_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         cnt_q    <= cnt_d;
      end
   end

   // Output decode. The bus signals come straight from registers that were
   // latched at accept, so they stay stable for the whole of WAIT. The
   // response fields are qualified with RESP so that they read 0 elsewhere.
   always_comb begin
      req_ready        = (state_q == StIdle);
      resp_valid       = (state_q == StResp);
      resp_err         = (state_q == StResp) && err_q;
      resp_rdata       = (state_q == StResp) ? rdata_q : 32'h0;
      mem_write_enable = (state_q == StWait) && we_q;
      mem_read_enable  = (state_q == StWait) && !we_q;
      mem_strb         = strb_q;
      mem_write_data   = wdata_q;
      mem_write_addr   = addr_q;
      mem_read_addr    = addr_q;
   end

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_adapter
//
// Self-checking bench for lsu_mem_adapter, with TIMEOUT_CYCLES set to 4.
// A table of load/store vectors is applied in a loop. Each expected response
// is pushed to a scoreboard queue when its request is driven. A monitor pops
// the queue on every resp_valid pulse. Hand-written sequences cover the
// timeout and the reset taken in the middle of WAIT.
// -----------------------------------------------------------------------------
module tb_lsu_mem_adapter;

   localparam int unsigned TOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [3:0]  mem_strb;
   logic [31:0] mem_write_data;
   logic [31:0] mem_write_addr;
   logic [31:0] mem_read_addr;
   logic        mem_write_enable;
   logic        mem_read_enable;
   logic [31:0] mem_read_data;
   logic        mem_done;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
      logic        access;
      logic [31:0] expAddr;
      logic [3:0]  expStrb;
      logic [31:0] expWdata;
      logic        expErr;
      logic [31:0] expRdata;
   } vecT;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
   } respT;

   respT sbQ[$];
   vecT  vec[$];
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   lsu_mem_adapter #(.TIMEOUT_CYCLES(TOUT)) dut (
      .clk              (clk),
      .reset            (reset),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_we           (req_we),
      .req_funct3       (req_funct3),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .resp_valid       (resp_valid),
      .resp_err         (resp_err),
      .resp_rdata       (resp_rdata),
      .mem_strb         (mem_strb),
      .mem_write_data   (mem_write_data),
      .mem_write_addr   (mem_write_addr),
      .mem_read_addr    (mem_read_addr),
      .mem_write_enable (mem_write_enable),
      .mem_read_enable  (mem_read_enable),
      .mem_read_data    (mem_read_data),
      .mem_done         (mem_done)
   );

   // Single comparison point: every check counts, and every miss prints a line.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vecT mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int dly,
                              input logic access, input logic [31:0] expAddr,
                              input logic [3:0] expStrb,
                              input logic [31:0] expWdata,
                              input logic expErr, input logic [31:0] expRdata);
      vecT v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.dly = dly; v.access = access; v.expAddr = expAddr;
      v.expStrb = expStrb; v.expWdata = expWdata; v.expErr = expErr;
      v.expRdata = expRdata;
      return v;
   endfunction

   // Response monitor: each resp_valid pulse must match the oldest expected
   // response. A pulse with nothing outstanding is an error.
   always @(negedge clk) begin : monitor
      respT e;
      if (!reset && resp_valid === 1'b1) begin
         if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_resp: got err=%0b rdata=0x%08h expected no response",
                     resp_err, resp_rdata);
         end else begin
            e = sbQ.pop_front();
            checkOutput("resp_err", 32'(resp_err), 32'(e.err));
            checkOutput("resp_rdata", resp_rdata, e.rdata);
         end
      end
   end

   // Check the bus-side view during one WAIT cycle of an access.
   task automatic checkBus(input vecT v);
      checkOutput("wr_en", 32'(mem_write_enable), 32'(v.we));
      checkOutput("rd_en", 32'(mem_read_enable), 32'(!v.we));
      checkOutput("strb", 32'(mem_strb), 32'(v.expStrb));
      if (v.we) begin
         checkOutput("wr_addr", mem_write_addr, v.expAddr);
         checkOutput("wr_data", mem_write_data, v.expWdata);
      end else begin
         checkOutput("rd_addr", mem_read_addr, v.expAddr);
      end
   endtask

   task automatic waitDrain(input string name);
      int guard = 0;
      while (sbQ.size() != 0 && guard < 12) begin
         @(negedge clk);
         guard++;
      end
      if (sbQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_no_resp: got %0d pending expected 0", name, sbQ.size());
         sbQ.delete();
      end
   endtask

   // Drive one request at a negedge and play the bridge for it.
   task automatic applyStimulus(input vecT v);
      int guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout: got 0 expected 1");
      end
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      sbQ.push_back('{err: v.expErr, rdata: v.expRdata});
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("ready_busy", 32'(req_ready), 32'h0);
      if (v.access) begin
         for (int i = 0; i <= v.dly; i++) begin
            if (i > 0) @(negedge clk);
            checkBus(v);
         end
         mem_done      = 1'b1;
         mem_read_data = v.rdata;
         @(negedge clk);
         mem_done      = 1'b0;
         mem_read_data = 32'h0;
         checkOutput("en_low_resp", 32'({mem_write_enable, mem_read_enable}), 32'h0);
      end else begin
         checkOutput("err_no_en", 32'({mem_write_enable, mem_read_enable}), 32'h0);
         checkOutput("err_latency", 32'(resp_valid), 32'h1);
      end
      waitDrain("vec");
   endtask

   initial begin
      reset         = 1'b1;
      req_valid     = 1'b0;
      req_we        = 1'b0;
      req_funct3    = 3'b000;
      req_addr      = 32'h0;
      req_wdata     = 32'h0;
      mem_read_data = 32'h0;
      mem_done      = 1'b0;

      //             we  f3      addr        wdata         rdata     dly acc expAddr     strb     expWdata      err expRdata
      vec.push_back(mk(1, 3'b000, 32'h103, 32'h000000A5, 32'h0,          0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 0, 32'h0));
      vec.push_back(mk(0, 3'b000, 32'h102, 32'h0,        32'h12803456,   0, 1, 32'h100, 4'b0000, 32'h0,        0, 32'hFFFFFF80));
      vec.push_back(mk(0, 3'b100, 32'h102, 32'h0,        32'h12803456,   1, 1, 32'h100, 4'b0000, 32'h0,        0, 32'h00000080));
      vec.push_back(mk(0, 3'b001, 32'h002, 32'h0,        32'h80017FFF,   0, 1, 32'h000, 4'b0000, 32'h0,        0, 32'hFFFF8001));
      vec.push_back(mk(0, 3'b101, 32'h002, 32'h0,        32'h80017FFF,   2, 1, 32'h000, 4'b0000, 32'h0,        0, 32'h00008001));
      vec.push_back(mk(0, 3'b010, 32'h004, 32'h0,        32'hDEADBEEF,   0, 1, 32'h004, 4'b0000, 32'h0,        0, 32'hDEADBEEF));
      vec.push_back(mk(1, 3'b001, 32'h002, 32'h1234ABCD, 32'h0,          1, 1, 32'h000, 4'b1100, 32'hABCDABCD, 0, 32'h0));
      vec.push_back(mk(1, 3'b010, 32'h008, 32'hCAFEF00D, 32'h0,          0, 1, 32'h008, 4'b1111, 32'hCAFEF00D, 0, 32'h0));
      vec.push_back(mk(0, 3'b011, 32'h010, 32'h0,        32'h0,          0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0));
      vec.push_back(mk(1, 3'b100, 32'h010, 32'h55555555, 32'h0,          0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0));
`ifdef MISALIGN_TRAP_EN
      vec.push_back(mk(0, 3'b010, 32'h006, 32'h0,        32'h11223344,   0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0));
      vec.push_back(mk(0, 3'b001, 32'h003, 32'h0,        32'h7FFF0000,   0, 0, 32'h0,   4'b0000, 32'h0,        1, 32'h0));
`else
      vec.push_back(mk(0, 3'b010, 32'h006, 32'h0,        32'h11223344,   0, 1, 32'h004, 4'b0000, 32'h0,        0, 32'h11223344));
      vec.push_back(mk(0, 3'b001, 32'h003, 32'h0,        32'h7FFF0000,   0, 1, 32'h000, 4'b0000, 32'h0,        0, 32'h00007FFF));
`endif
      // mem_done arrives in the same cycle as the timeout, so the data wins.
      vec.push_back(mk(0, 3'b000, 32'h001, 32'h0,        32'h0000FF00,   3, 1, 32'h000, 4'b0000, 32'h0,        0, 32'hFFFFFFFF));
      vec.push_back(mk(1, 3'b000, 32'h000, 32'hFFFFFF7E, 32'h0,          2, 1, 32'h000, 4'b0001, 32'h7E7E7E7E, 0, 32'h0));

      // Reset state
      #1;
      checkOutput("rst_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_resp", 32'({resp_valid, resp_err}), 32'h0);
      checkOutput("rst_rdata", resp_rdata, 32'h0);
      checkOutput("rst_en", 32'({mem_write_enable, mem_read_enable}), 32'h0);
      checkOutput("rst_strb", 32'(mem_strb), 32'h0);
      checkOutput("rst_wdata", mem_write_data, 32'h0);
      checkOutput("rst_addr", mem_write_addr | mem_read_addr, 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      foreach (vec[i]) applyStimulus(vec[i]);

      // Timeout: no mem_done, so the load must give up after TOUT WAIT cycles.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      sbQ.push_back('{err: 1'b1, rdata: 32'h0});
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < int'(TOUT); i++) begin
         @(negedge clk);
         checkOutput("tout_rd_en", 32'(mem_read_enable), 32'h1);
         checkOutput("tout_no_resp", 32'(resp_valid), 32'h0);
      end
      @(negedge clk);
      checkOutput("tout_resp", 32'(resp_valid), 32'h1);
      checkOutput("tout_en_low", 32'(mem_read_enable), 32'h0);
      waitDrain("tout");

      // Reset in the middle of WAIT: drop everything, no response.
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h40;
      req_wdata  = 32'h87654321;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("mid_wr_en", 32'(mem_write_enable), 32'h1);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_en", 32'({mem_write_enable, mem_read_enable}), 32'h0);
      checkOutput("mid_rst_ready", 32'(req_ready), 32'h1);
      checkOutput("mid_rst_strb", 32'(mem_strb), 32'h0);
      checkOutput("mid_rst_addr", mem_write_addr, 32'h0);
      checkOutput("mid_rst_resp", 32'(resp_valid), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("post_rst_idle", 32'(req_ready), 32'h1);

      // Normal operation resumes after the reset.
      applyStimulus(mk(0, 3'b010, 32'h004, 32'h0, 32'hDEADBEEF, 0, 1,
                       32'h004, 4'b0000, 32'h0, 0, 32'hDEADBEEF));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
